// File: rtl/hdc_pkg.sv
// Shared constants, types and FSM encoding for the hypervector inference path.
package hdc_pkg;

  localparam int unsigned FRAME_W     = 64;
  localparam int unsigned NUM_FRAMES  = 3;
  localparam int unsigned NUM_CLASSES = 8;
  localparam int unsigned DIST_W      = 8;

  localparam int unsigned CNT_W  = $clog2(FRAME_W + 1);
  localparam int unsigned CLS_W  = $clog2(NUM_CLASSES);
  localparam int unsigned FIDX_W = $clog2(NUM_FRAMES);

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SWEEP = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/class_search_ctrl_if.sv
// Query stream, class ROM address/data and result handshake of the search controller.
interface class_search_ctrl_if;
  import hdc_pkg::*;

  logic              q_valid;
  logic              q_ready;
  frame_t            q_data;
  logic [CLS_W-1:0]  cv_frame_id;
  logic [FIDX_W-1:0] cv_frame_index;
  frame_t            cv_data;
  logic              res_valid;
  logic              res_ready;
  logic [CLS_W-1:0]  res_class;
  logic [DIST_W-1:0] res_dist;

  modport master (
    output q_valid, q_data, cv_data, res_ready,
    input  q_ready, cv_frame_id, cv_frame_index, res_valid, res_class, res_dist
  );

  modport slave (
    input  q_valid, q_data, cv_data, res_ready,
    output q_ready, cv_frame_id, cv_frame_index, res_valid, res_class, res_dist
  );
endinterface

// File: rtl/hvec_popcount.sv
// Combinational population count of one hypervector frame.
module hvec_popcount
  import hdc_pkg::*;
(
  input  frame_t           vec,
  output logic [CNT_W-1:0] cnt_c
);

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(FRAME_W); i++) begin
      cnt_c = cnt_c + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/class_search_ctrl.sv
// Buffers a query hypervector, sweeps the class ROM and reports the nearest class
// by Hamming distance (ties resolved towards the lower class index).
module class_search_ctrl
  import hdc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  class_search_ctrl_if.slave bus
);

  localparam logic [FIDX_W-1:0] LAST_FIDX = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

  state_t            state, state_next;
  frame_t            qbuf [NUM_FRAMES];
  logic [FIDX_W-1:0] ld_idx, fidx;
  logic [CLS_W-1:0]  cls, pc_cls, best_class, res_class_q;
  logic [CNT_W-1:0]  pc_q, pc_c;
  logic              pc_vld, pc_last;
  logic [DIST_W-1:0] acc, acc_next, best_dist, res_dist_q;
  logic              q_fire, last_beat, last_addr, better;

  hvec_popcount u_popcount (
    .vec   (bus.cv_data ^ qbuf[fidx]),
    .cnt_c (pc_c)
  );

  // Address counters are held at zero outside SWEEP, so they drive the ROM directly.
  assign bus.cv_frame_id    = cls;
  assign bus.cv_frame_index = fidx;
  assign bus.res_class      = res_class_q;
  assign bus.res_dist       = res_dist_q;

  always_comb begin
    state_next = state;
    q_fire     = bus.q_ready && bus.q_valid;
    last_beat  = q_fire && (ld_idx == LAST_FIDX);
    last_addr  = (cls == LAST_CLS) && (fidx == LAST_FIDX);
    acc_next   = acc + DIST_W'(pc_q);
    better     = pc_vld && pc_last && (acc_next < best_dist);
    case (state)
      ST_IDLE:  if (start)                         state_next = ST_LOAD;
      ST_LOAD:  if (last_beat)                     state_next = ST_SWEEP;
      ST_SWEEP: if (last_addr)                     state_next = ST_DRAIN;
      ST_DRAIN:                                    state_next = ST_DONE;
      ST_DONE:  if (bus.res_valid && bus.res_ready) state_next = ST_IDLE;
      default:                                     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      bus.q_ready   <= 1'b0;
      bus.res_valid <= 1'b0;
      for (int i = 0; i < int'(NUM_FRAMES); i++) qbuf[i] <= '0;
      ld_idx        <= '0;
      fidx          <= '0;
      cls           <= '0;
      pc_q          <= '0;
      pc_cls        <= '0;
      pc_vld        <= 1'b0;
      pc_last       <= 1'b0;
      acc           <= '0;
      best_dist     <= '0;
      best_class    <= '0;
      res_dist_q    <= '0;
      res_class_q   <= '0;
    end else begin
      state         <= state_next;
      busy          <= (state_next != ST_IDLE);
      bus.q_ready   <= (state_next == ST_LOAD);
      bus.res_valid <= (state_next == ST_DONE);

      if (q_fire) begin
        qbuf[ld_idx] <= bus.q_data;
        ld_idx       <= last_beat ? '0 : ld_idx + FIDX_W'(1);
      end

      // One ROM address per cycle: frame inner, class outer.
      pc_vld <= (state == ST_SWEEP);
      if (state == ST_SWEEP) begin
        pc_q    <= pc_c;
        pc_cls  <= cls;
        pc_last <= (fidx == LAST_FIDX);
        if (fidx == LAST_FIDX) begin
          fidx <= '0;
          cls  <= last_addr ? '0 : cls + CLS_W'(1);
        end else begin
          fidx <= fidx + FIDX_W'(1);
        end
      end

      if (last_beat) begin
        acc        <= '0;
        best_dist  <= '1;
        best_class <= '0;
      end else if (pc_vld) begin
        acc <= pc_last ? '0 : acc_next;
        if (better) begin
          best_dist  <= acc_next;
          best_class <= pc_cls;
        end
      end

      // DRAIN folds the final class compare straight into the result registers.
      if (state == ST_DRAIN) begin
        res_dist_q  <= better ? acc_next : best_dist;
        res_class_q <= better ? pc_cls   : best_class;
      end
    end
  end

endmodule

// File: tb/tb_class_search_ctrl.sv
// Randomized self-checking bench for class_search_ctrl with a behavioural ROM and model.
module tb_class_search_ctrl;
  import hdc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;

  class_search_ctrl_if bus ();

  class_search_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  frame_t rom [8][4];
  frame_t qry [3];
  int     errors = 0;
  int     checks = 0;

  always_comb bus.cv_data = rom[bus.cv_frame_id][bus.cv_frame_index];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Nearest class by summed Hamming distance; strict less keeps the lower index on ties.
  task automatic model(output int best_c, output int best_d);
    best_c = 0;
    best_d = 1 << 30;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      int d = 0;
      for (int f = 0; f < int'(NUM_FRAMES); f++) d += $countones(rom[c][f] ^ qry[f]);
      if (d < best_d) begin
        best_d = d;
        best_c = c;
      end
    end
  endtask

  function automatic frame_t rnd_frame();
    return {$urandom(), $urandom()};
  endfunction

  task automatic fill_rom_random();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++) rom[c][f] = rnd_frame();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a search and streams the query with `gap` idle cycles before each beat.
  task automatic send_query(input string tag, input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < int'(NUM_FRAMES); i++) begin
      for (int g = 0; g < gap; g++) begin
        chk({tag, "_q_ready_gap"}, 32'(bus.q_ready), 32'd1);
        tick();
      end
      bus.q_valid = 1'b1;
      bus.q_data  = qry[i];
      chk({tag, "_q_ready_beat"}, 32'(bus.q_ready), 32'd1);
      if (i == 0) chk({tag, "_cv_id_in_load"}, 32'(bus.cv_frame_id), 32'd0);
      tick();
      bus.q_valid = 1'b0;
      bus.q_data  = '0;
    end
  endtask

  task automatic run_search(input string tag, input int gap, input bit check_lat);
    int lat;
    int exp_c, exp_d;
    model(exp_c, exp_d);
    send_query(tag, gap);
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    if (check_lat) chk({tag, "_latency"}, 32'(lat), 32'd25);
    chk({tag, "_res_class"}, 32'(bus.res_class), 32'(exp_c));
    chk({tag, "_res_dist"}, 32'(bus.res_dist), 32'(exp_d));
    chk({tag, "_cv_id_done"}, 32'(bus.cv_frame_id), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [CLS_W-1:0]  held_c;
    logic [DIST_W-1:0] held_d;
    int exp_c, exp_d;

    rst_n         = 1'b0;
    start         = 1'b0;
    bus.q_valid   = 1'b0;
    bus.q_data    = '0;
    bus.res_ready = 1'b0;
    fill_rom_random();
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_q_ready", 32'(bus.q_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_class", 32'(bus.res_class), 32'd0);
    chk("rst_res_dist", 32'(bus.res_dist), 32'd0);
    chk("rst_cv_id", 32'(bus.cv_frame_id), 32'd0);
    chk("rst_cv_index", 32'(bus.cv_frame_index), 32'd0);
    rst_n = 1'b1;
    tick();

    // Query equal to class 0.
    for (int f = 0; f < 3; f++) qry[f] = rom[0][f];
    run_search("exact0", 0, 1'b1);

    // Only class 5 is all-ones; query all-ones.
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++) rom[c][f] = (c == 5) ? '1 : '0;
    for (int f = 0; f < 3; f++) qry[f] = '1;
    run_search("stub5", 0, 1'b1);

    // All classes identical: tie must keep class 0.
    for (int f = 0; f < 4; f++) rom[0][f] = rnd_frame();
    for (int c = 1; c < 8; c++)
      for (int f = 0; f < 4; f++) rom[c][f] = rom[0][f];
    for (int f = 0; f < 3; f++) qry[f] = rnd_frame();
    run_search("tie", 0, 1'b1);

    // Same query with 3-cycle valid gaps before every beat.
    run_search("gaps", 3, 1'b1);

    // Random ROMs and near-miss queries.
    for (int t = 0; t < 6; t++) begin
      fill_rom_random();
      n = $urandom_range(7);
      for (int f = 0; f < 3; f++) qry[f] = rom[n][f] ^ (rnd_frame() & rnd_frame() & rnd_frame());
      run_search("rand", $urandom_range(2), 1'b1);
    end

    // Result held under back-pressure while start is pulsed.
    fill_rom_random();
    for (int f = 0; f < 3; f++) qry[f] = rnd_frame();
    model(exp_c, exp_d);
    send_query("hold", 0);
    n = 0;
    while (!bus.res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
    held_c = bus.res_class;
    held_d = bus.res_dist;
    chk("hold_class", 32'(held_c), 32'(exp_c));
    chk("hold_dist", 32'(held_d), 32'(exp_d));
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      chk("hold_valid_stable", 32'(bus.res_valid), 32'd1);
      chk("hold_class_stable", 32'(bus.res_class), 32'(held_c));
      chk("hold_dist_stable", 32'(bus.res_dist), 32'(held_d));
      chk("hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    bus.res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.res_ready = 1'b0;
    chk("hold_release_valid", 32'(bus.res_valid), 32'd0);
    chk("hold_release_busy", 32'(busy), 32'd0);
    tick();
    chk("hold_no_restart", 32'(busy), 32'd0);

    // Asynchronous reset mid-sweep at address (3,1).
    fill_rom_random();
    for (int f = 0; f < 3; f++) qry[f] = rnd_frame();
    send_query("arst", 0);
    n = 0;
    while (!(bus.cv_frame_id == 3'd3 && bus.cv_frame_index == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    chk("arst_reach_addr", 32'(bus.cv_frame_id == 3'd3 && bus.cv_frame_index == 2'd1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q_ready", 32'(bus.q_ready), 32'd0);
    chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_res_class", 32'(bus.res_class), 32'd0);
    chk("arst_res_dist", 32'(bus.res_dist), 32'd0);
    chk("arst_cv_id", 32'(bus.cv_frame_id), 32'd0);
    chk("arst_cv_index", 32'(bus.cv_frame_index), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    n = $urandom_range(7);
    for (int f = 0; f < 3; f++) qry[f] = rom[n][f] ^ (rnd_frame() & rnd_frame());
    run_search("post_rst", 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/class_search_ctrl.md
# class_search_ctrl

Sequencer for the class hypervector ROM (`class_vec_gen`) in the inference path. It buffers one query hypervector, delivered as `NUM_FRAMES` frames. It then sweeps every (class, frame) address of the ROM, accumulates the per-class Hamming distance, and returns the closest class. The block drives the ROM address ports and consumes its combinational data; the ROM itself stays external so it can be regenerated per model.

## Interface
Parameters:
- `FRAME_W`, 64: bits per frame.
- `NUM_FRAMES`, 3: frames per hypervector.
- `NUM_CLASSES`, 8: number of classes.
- `DIST_W`, 8: distance width; must satisfy 2^DIST_W > FRAME_W*NUM_FRAMES.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to begin a search.
- `busy` out 1: high in every state except IDLE.
- `q_valid` in 1, `q_ready` out 1, `q_data` in FRAME_W: query frame stream, sent frame 0 first.
- `cv_frame_id` out 3: ROM class select.
- `cv_frame_index` out 2: ROM frame select.
- `cv_data` in FRAME_W: ROM output, combinational from the cv_* outputs.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_class` out 3: winning class.
- `res_dist` out DIST_W: Hamming distance of the winning class.

## Operation
- FSM states: IDLE, LOAD, SWEEP, DRAIN, DONE.
- IDLE: `start`=1 moves to LOAD on the next edge. `start` is ignored in all other states.
- LOAD:
  - `q_ready`=1. Each beat with `q_valid && q_ready` stores `q_data` into query buffer slot `fidx`, then increments `fidx`.
  - `q_valid` gaps stall the load without loss.
  - After beat NUM_FRAMES-1 is accepted: go to SWEEP, clear counters, set best=all-ones.
- SWEEP:
  - Presents address (cls, fidx) on `cv_frame_id`/`cv_frame_index`; `fidx` is inner, `cls` is outer. One address per cycle, no stalls.
  - Each cycle registers popcount(`cv_data` ^ qbuf[fidx]) into `pc_q`, tagged with cls and a last-frame flag.
  - On the cycle after each registered popcount: acc_next = acc + `pc_q`.
  - On a last-frame tag: if acc_next < best (strictly less), update best_dist and best_class; clear acc. Ties keep the lower class index.
  - After address (NUM_CLASSES-1, NUM_FRAMES-1): go to DRAIN.
- DRAIN: one cycle that consumes the final `pc_q` and does the final compare. Then go to DONE.
- DONE:
  - `res_valid`=1; `res_class`/`res_dist` are held stable.
  - On `res_valid && res_ready`: go to IDLE and drop `res_valid` on the next edge.
  - `start` in the handshake cycle is ignored.
- Arithmetic:
  - popcount is FRAME_W-bit, result 7 bits, zero-extended to DIST_W.
  - acc cannot overflow by the parameter rule.
- `cv_frame_id`/`cv_frame_index` read 0 outside SWEEP.

## Timing
- Reset values: busy=0, q_ready=0, res_valid=0, res_class=0, res_dist=0, cv_frame_id=0, cv_frame_index=0. FSM=IDLE; acc, best and the query buffer are cleared.
- `start` at edge T: `busy` and `q_ready` are high after T+1.
- Last query beat accepted at edge E:
  - SWEEP occupies E..E+24 (NUM_CLASSES*NUM_FRAMES = 24 cycles).
  - DRAIN: 1 cycle.
  - `res_valid` is high after edge E+25.
- Minimum start-to-result: 1 + NUM_FRAMES + 25 cycles.
- Asserting `rst_n` low in any state returns all outputs to their reset values immediately. A partial query is discarded.
- `res_ready` high while not in DONE has no effect.

## Structure
- Shared package `hdc_pkg` holds:
  - Constants: FRAME_W, NUM_FRAMES, NUM_CLASSES, DIST_W.
  - The FSM state enum.
  - A typedef for the frame word.
- Sub-module `hvec_popcount`: a combinational FRAME_W-bit popcount, reused by the training path.
- FSM, counters, query buffer, pipeline register and comparator live in `class_search_ctrl`.

## Test plan
- Real ROM, query = class 0 frames 0..2 → `res_class`=0, `res_dist`=0. `res_valid` rises exactly 25 cycles after the last beat.
- Stub ROM: all classes 64'h0 except class 5 = all-ones; query all-ones → `res_class`=5, `res_dist`=0. Class 0 distance is 192.
- Stub ROM: every class identical → `res_class`=0 (tie keeps the lower index), `res_dist` equal to the common distance.
- `q_valid` low for 3 cycles between each beat → identical result; `q_ready` stays high throughout LOAD.
- Result held with `res_ready`=0 for 10 cycles, `start` pulsed meanwhile → outputs stable, no restart. After `res_ready`=1: IDLE, `busy`=0.
- `rst_n` low mid-SWEEP (address class 3, frame 1) → all outputs 0 immediately. A new search afterwards returns the correct class.
